// File: rtl/btn_scan_ctrl.sv
// Round-robin debounce scheduler: one tick and one stability comparator shared by all buttons,
// rising debounced edges queued as press events over valid/ready, accepted presses toggle LEDs.
module btn_scan_ctrl #(
   parameter int unsigned N_BTN        = 4,
   parameter int unsigned ID_W         = 2,
   parameter int unsigned SAMPLE_DIV   = 1000,
   parameter int unsigned STABLE_TICKS = 8,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn,
   output logic [N_BTN-1:0] db_level,
   output logic             press_valid,
   input  logic             press_ready,
   output logic [ID_W-1:0]  press_id,
   output logic [N_BTN-1:0] led_driver,
   output logic             ovf
);

   localparam int unsigned SC_W = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;

   typedef enum logic {ST_IDLE, ST_HOLD} state_e;

   logic [N_BTN-1:0] sync1_q;
   logic [N_BTN-1:0] bs_q;
   logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
   logic             tick_c;
   logic [ID_W-1:0]  scan_idx_q, scan_idx_d;
   logic [SC_W-1:0]  stab_cnt_q [N_BTN];
   logic [SC_W-1:0]  stab_cnt_d [N_BTN];
   logic [N_BTN-1:0] db_level_q, db_level_d;
   logic [N_BTN-1:0] rise_c;
   logic [N_BTN-1:0] pending_q, pending_d;
   logic [N_BTN-1:0] take_c;
   logic             ovf_q, ovf_d;
   logic [ID_W-1:0]  rr_ptr_q;
   logic [ID_W-1:0]  sel_c;
   logic [ID_W-1:0]  cand_c;
   logic             any_pend_c;
   state_e           state_q;
   logic             press_valid_q;
   logic [ID_W-1:0]  press_id_q;
   logic [N_BTN-1:0] led_q;

   assign tick_c     = (tick_cnt_q == CNT_W'(SAMPLE_DIV - 1));
   assign tick_cnt_d = tick_c ? '0 : tick_cnt_q + CNT_W'(1);
   // N_BTN is a power of two, so the index wraps naturally
   assign scan_idx_d = tick_c ? scan_idx_q + ID_W'(1) : scan_idx_q;

   // Shared stability comparator for the button currently being visited
   always_comb begin
      stab_cnt_d = stab_cnt_q;
      db_level_d = db_level_q;
      rise_c     = '0;
      if (tick_c) begin
         if (bs_q[scan_idx_q] == db_level_q[scan_idx_q]) begin
            stab_cnt_d[scan_idx_q] = '0;
         end else if (stab_cnt_q[scan_idx_q] == SC_W'(STABLE_TICKS - 1)) begin
            db_level_d[scan_idx_q] = bs_q[scan_idx_q];
            stab_cnt_d[scan_idx_q] = '0;
            rise_c[scan_idx_q]     = bs_q[scan_idx_q];
         end else begin
            stab_cnt_d[scan_idx_q] = stab_cnt_q[scan_idx_q] + SC_W'(1);
         end
      end
   end

   // Descending scan so the closest set bit at or after rr_ptr wins
   always_comb begin
      sel_c      = rr_ptr_q;
      cand_c     = rr_ptr_q;
      any_pend_c = 1'b0;
      for (int k = N_BTN - 1; k >= 0; k--) begin
         cand_c = rr_ptr_q + ID_W'(k);
         if (pending_q[cand_c]) begin
            sel_c      = cand_c;
            any_pend_c = 1'b1;
         end
      end
   end

   // A new rise wins over the same-edge dispatch clear and is not an overflow
   always_comb begin
      take_c    = (state_q == ST_IDLE && any_pend_c) ? (N_BTN'(1) << sel_c) : '0;
      pending_d = (pending_q & ~take_c) | rise_c;
      ovf_d     = ovf_q | (|(rise_c & pending_q & ~take_c));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q       <= '0;
         bs_q          <= '0;
         tick_cnt_q    <= '0;
         scan_idx_q    <= '0;
         stab_cnt_q    <= '{default: '0};
         db_level_q    <= '0;
         pending_q     <= '0;
         ovf_q         <= 1'b0;
         rr_ptr_q      <= '0;
         state_q       <= ST_IDLE;
         press_valid_q <= 1'b0;
         press_id_q    <= '0;
         led_q         <= '0;
      end else begin
         sync1_q    <= btn;
         bs_q       <= sync1_q;
         tick_cnt_q <= tick_cnt_d;
         scan_idx_q <= scan_idx_d;
         stab_cnt_q <= stab_cnt_d;
         db_level_q <= db_level_d;
         pending_q  <= pending_d;
         ovf_q      <= ovf_d;
         if (state_q == ST_IDLE) begin
            if (any_pend_c) begin
               press_id_q    <= sel_c;
               press_valid_q <= 1'b1;
               rr_ptr_q      <= sel_c + ID_W'(1);
               state_q       <= ST_HOLD;
            end
         end else begin
            if (press_valid_q && press_ready) begin
               press_valid_q      <= 1'b0;
               led_q[press_id_q]  <= ~led_q[press_id_q];
               state_q            <= ST_IDLE;
            end
         end
      end
   end

   assign db_level    = db_level_q;
   assign press_valid = press_valid_q;
   assign press_id    = press_id_q;
   assign led_driver  = led_q;
   assign ovf         = ovf_q;

endmodule

// File: tb/tb_btn_scan_ctrl.sv
// Bench for btn_scan_ctrl: directed scenarios plus random button/ready traffic,
// every cycle compared against a behavioural model of debounce, arbitration and toggling.
module tb_btn_scan_ctrl;

   localparam int unsigned N   = 4;
   localparam int unsigned IDW = 2;
   localparam int unsigned SD  = 2;
   localparam int unsigned ST  = 3;
   localparam int unsigned CW  = 16;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   btn = '0;
   logic           press_ready = 1'b0;
   logic [N-1:0]   db_level;
   logic           press_valid;
   logic [IDW-1:0] press_id;
   logic [N-1:0]   led_driver;
   logic           ovf;

   btn_scan_ctrl #(
      .N_BTN(N), .ID_W(IDW), .SAMPLE_DIV(SD), .STABLE_TICKS(ST), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst(rst), .btn(btn), .db_level(db_level),
      .press_valid(press_valid), .press_ready(press_ready), .press_id(press_id),
      .led_driver(led_driver), .ovf(ovf)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: time since reset decides when and whom to sample
   int         m_age;
   bit [N-1:0] m_pipe1, m_pipe2;
   int         m_diff [N];
   bit [N-1:0] m_db, m_pend, m_led;
   int         m_rr, m_id;
   bit         m_busy, m_ovf;

   task automatic model_step();
      bit [N-1:0] seen;
      bit [N-1:0] old_pend;
      int b, rise, taken;
      if (rst) begin
         m_age = 0; m_pipe1 = '0; m_pipe2 = '0;
         for (int i = 0; i < N; i++) m_diff[i] = 0;
         m_db = '0; m_pend = '0; m_led = '0;
         m_rr = 0; m_id = 0; m_busy = 1'b0; m_ovf = 1'b0;
         return;
      end
      seen = m_pipe2; m_pipe2 = m_pipe1; m_pipe1 = btn;
      rise = -1;
      if (m_age % SD == SD - 1) begin
         b = (m_age / SD) % N;
         if (seen[b] != m_db[b]) begin
            m_diff[b]++;
            if (m_diff[b] == ST) begin
               m_db[b] = seen[b];
               m_diff[b] = 0;
               if (seen[b]) rise = b;
            end
         end else begin
            m_diff[b] = 0;
         end
      end
      m_age++;
      old_pend = m_pend;
      taken = -1;
      if (!m_busy) begin
         for (int k = 0; k < N; k++)
            if (taken < 0 && m_pend[(m_rr + k) % N]) taken = (m_rr + k) % N;
         if (taken >= 0) begin
            m_pend[taken] = 1'b0; m_busy = 1'b1; m_id = taken; m_rr = (taken + 1) % N;
         end
      end else if (press_ready) begin
         m_busy = 1'b0;
         m_led[m_id] = ~m_led[m_id];
      end
      if (rise >= 0) begin
         if (old_pend[rise] && taken != rise) m_ovf = 1'b1;
         m_pend[rise] = 1'b1;
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      check("db_level", 32'(db_level), 32'(m_db));
      check("press_valid", 32'(press_valid), 32'(m_busy));
      if (m_busy) check("press_id", 32'(press_id), 32'(m_id));
      check("led_driver", 32'(led_driver), 32'(m_led));
      check("ovf", 32'(ovf), 32'(m_ovf));
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      run(n);
      rst = 1'b0;
   endtask

   task automatic wait_valid(input string tag, input int limit);
      int w = 0;
      while (!press_valid && w < limit) begin
         cycle();
         w++;
      end
      check(tag, 32'(press_valid), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, n0, cnt0;
      bit seen_a, seen_b;
      int hold [N];

      // Reset with all buttons pressed
      btn = 4'b1111;
      do_reset(3);
      check("rst_db", 32'(db_level), 32'd0);
      check("rst_valid", 32'(press_valid), 32'd0);
      check("rst_led", 32'(led_driver), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      seen_a = 1'b0;
      for (int i = 0; i < 17; i++) begin
         cycle();
         if (db_level != 0) seen_a = 1'b1;
      end
      check("rst_early_flip", 32'(seen_a), 32'd0);
      run(40);

      // Clean press on button 1
      btn = '0; press_ready = 1'b1;
      do_reset(2);
      btn = 4'b0010;
      w = 0;
      while (!db_level[1] && w < 40) begin
         cycle();
         w++;
      end
      check("press_latency_ok", 32'(w <= 26), 32'd1);
      cycle();
      check("press_valid_pulse", 32'(press_valid), 32'd1);
      check("press_id_1", 32'(press_id), 32'd1);
      cycle();
      check("press_valid_drop", 32'(press_valid), 32'd0);
      check("press_led", 32'(led_driver), 32'b0010);
      run(60 - w - 2);
      btn = '0;
      seen_a = 1'b0;
      for (int i = 0; i < 40; i++) begin
         cycle();
         if (press_valid) seen_a = 1'b1;
      end
      check("release_db", 32'(db_level), 32'd0);
      check("release_no_event", 32'(seen_a), 32'd0);

      // Bounce on button 0: alternating samples never flip
      do_reset(2);
      seen_a = 1'b0; seen_b = 1'b0;
      for (int c = 0; c < 200; c++) begin
         btn[0] = 1'((c / 8) % 2);
         cycle();
         if (db_level[0]) seen_a = 1'b1;
         if (press_valid) seen_b = 1'b1;
      end
      check("bounce_db", 32'(seen_a), 32'd0);
      check("bounce_valid", 32'(seen_b), 32'd0);

      // Arbitration between buttons 2 and 3
      btn = '0; press_ready = 1'b0;
      do_reset(2);
      btn = 4'b1100;
      wait_valid("arb_first_valid", 40);
      check("arb_first_id", 32'(press_id), 32'd2);
      seen_a = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (!press_valid || press_id != 2'd2) seen_a = 1'b0;
      end
      check("arb_hold_stable", 32'(seen_a), 32'd1);
      press_ready = 1'b1;
      cycle();
      press_ready = 1'b0;
      check("arb_gap", 32'(press_valid), 32'd0);
      cycle();
      check("arb_second_valid", 32'(press_valid), 32'd1);
      check("arb_second_id", 32'(press_id), 32'd3);
      press_ready = 1'b1;
      cycle();
      press_ready = 1'b0;
      check("arb_led", 32'(led_driver), 32'b1100);

      // Overflow: second rise of button 0 while its first is still pending
      btn = '0;
      do_reset(2);
      btn = 4'b1000;
      wait_valid("ovf_hold_valid", 40);
      check("ovf_hold_id", 32'(press_id), 32'd3);
      btn = 4'b1001; run(40);
      btn = 4'b1000; run(40);
      btn = 4'b1001; run(40);
      check("ovf_set", 32'(ovf), 32'd1);
      press_ready = 1'b1;
      n0 = 0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (press_valid && press_id == 2'd0) n0++;
      end
      check("ovf_one_id0", 32'(n0), 32'd1);
      check("ovf_sticky", 32'(ovf), 32'd1);
      check("ovf_led", 32'(led_driver), 32'b1001);

      // Reset in the middle of a held event
      press_ready = 1'b0;
      btn = 4'b0100;
      wait_valid("midrst_valid", 40);
      rst = 1'b1; btn = '0;
      cycle();
      rst = 1'b0;
      check("midrst_valid", 32'(press_valid), 32'd0);
      check("midrst_led", 32'(led_driver), 32'd0);
      check("midrst_ovf", 32'(ovf), 32'd0);
      check("midrst_db", 32'(db_level), 32'd0);
      seen_a = 1'b0;
      for (int i = 0; i < 40; i++) begin
         cycle();
         if (press_valid) seen_a = 1'b1;
      end
      check("midrst_no_pending", 32'(seen_a), 32'd0);

      // Random traffic against the model
      for (int i = 0; i < N; i++) hold[i] = $urandom_range(1, 50);
      cnt0 = 0;
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < N; i++) begin
            hold[i]--;
            if (hold[i] <= 0) begin
               btn[i] = ~btn[i];
               hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : $urandom_range(20, 70);
            end
         end
         press_ready = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 1499) == 0);
         cycle();
         if (press_valid) cnt0++;
      end
      rst = 1'b0;
      check("random_saw_events", 32'(cnt0 > 0), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
